// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants: datapath widths, the NOP encoding,
// and the IF/ID payload consumed by decode.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

  // Empty IF/ID slot, used both on reset and on a redirect flush.
  localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register: flush inserts a bubble and takes priority over
// hold, which freezes the current contents.
module ifid_latch
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the instruction-memory address and
// loads IF/ID, honouring redirect (flush) over stall (hold).
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  count;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  // Next-PC selection; the low two redirect bits are forced to word alignment.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= '0;
    end else begin
      pc <= pc_next;
      if (!redirect && !stall) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ifid_d       = IFID_BUBBLE;
    ifid_d.pc    = pc;
    ifid_d.instr = imem_rdata;
    ifid_d.valid = 1'b1;
  end

  ifid_latch u_ifid_latch (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .flush (redirect),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr   = pc;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/
// reset traffic, all checked against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [63:0] NOP = 64'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [63:0] fetch_count;

  int passed = 0;
  int total  = 0;

  // Model state
  logic [63:0] m_pc;
  logic [63:0] m_ifid_pc;
  logic [31:0] m_ifid_instr;
  logic        m_ifid_valid;
  logic [63:0] m_count;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_valid  (ifid_valid),
    .fetch_count (fetch_count)
  );

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".imem_addr"},   imem_addr,           m_pc);
    chk({tag, ".ifid_pc"},     ifid_pc,             m_ifid_pc);
    chk({tag, ".ifid_instr"},  64'(ifid_instr),     64'(m_ifid_instr));
    chk({tag, ".ifid_valid"},  64'(ifid_valid),     64'(m_ifid_valid));
    chk({tag, ".fetch_count"}, fetch_count,         m_count);
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, check.
  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [63:0] rpc, input string tag);
    @(negedge clk);
    reset = r; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_ifid_instr = NOP[31:0];
      m_ifid_valid = 1'b0; m_count = 64'h0;
    end else if (rd) begin
      m_pc = rpc & ~64'h3;
      m_ifid_pc = 64'h0; m_ifid_instr = NOP[31:0]; m_ifid_valid = 1'b0;
    end else if (!st) begin
      m_ifid_pc = m_pc; m_ifid_instr = mem_fn(m_pc); m_ifid_valid = 1'b1;
      m_pc = m_pc + 64'd4;
      m_count = m_count + 64'd1;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_pc = '0; m_ifid_pc = '0; m_ifid_instr = NOP[31:0]; m_ifid_valid = 1'b0; m_count = '0;

    step(1, 0, 0, 0, "reset0");
    step(1, 0, 0, 0, "reset1");

    // First fetch from address 0
    step(0, 0, 0, 0, "first");
    chk("first.instr_const", 64'(ifid_instr), 64'h8B020020);
    chk("first.addr_const",  imem_addr,       64'h4);

    // Stall at pc=8 for three cycles, then release
    step(0, 0, 0, 0, "to8");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "stall8");
    chk("stall8.addr_const", imem_addr, 64'h8);
    step(0, 0, 0, 0, "release8");
    chk("release8.ifid_pc_const", ifid_pc, 64'h8);

    // Redirect from pc=20 to 0x103 -> 0x100
    step(0, 0, 0, 0, "to16");
    step(0, 0, 0, 0, "to20");
    chk("at20.addr_const", imem_addr, 64'd20);
    step(0, 0, 1, 64'h103, "redir103");
    chk("redir103.addr_const", imem_addr, 64'h100);
    step(0, 0, 0, 0, "after_redir");
    chk("after_redir.ifid_pc_const", ifid_pc, 64'h100);

    // Redirect beats stall
    step(0, 1, 1, 64'h40, "stall_redir");
    chk("stall_redir.addr_const", imem_addr, 64'h40);

    // PC wrap at top of address space
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, "redir_top");
    step(0, 0, 0, 0, "wrap");
    chk("wrap.addr_const",    imem_addr, 64'h0);
    chk("wrap.ifid_pc_const", ifid_pc,   64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, "post_wrap");

    // Reset in the middle of a stall
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, "pre_rst_stall");
    step(1, 1, 0, 0, "rst_in_stall");
    chk("rst_in_stall.count_const", fetch_count, 64'h0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, "post_rst_stall");
    step(0, 0, 0, 0, "post_rst_run");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r, st, rd;
      logic [63:0] rpc;
      r   = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'($urandom), 32'($urandom)};
      step(r, st, rd, rpc, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
